// File: rtl/sram_bank_access_ctrl.sv
// Requester-side controller for one single-port SRAM bank.
// Arbitrates a write and a read request stream onto the bank pins, one access
// per cycle. Read data returns one cycle later and is captured into a small
// response FIFO. Reads are credit-limited so returned data is never dropped.
//
// Handshake semantics (all three streams): a beat transfers in a cycle where
// valid and ready are both high. ready may depend combinationally on valid.
// A requester must hold valid and its payload until the beat transfers.
// rd_data_valid/rd_data form the response stream; rd_data is the FIFO head
// and stays stable until it is popped.
module sram_bank_access_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int OUT_DEPTH   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] wr_data,
  input  logic                              rd_valid,
  output logic                              rd_ready,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic                              rd_data_valid,
  input  logic                              rd_data_ready,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]             mem_addr_in_bank,
  output logic                              mem_cen_in_bank,
  output logic                              mem_wen_in_bank,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem_data_in_bank,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem_data_out_bank
);

  localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

  // Which side wins the next contended cycle.
  typedef enum logic {
    SIDE_READ  = 1'b0,
    SIDE_WRITE = 1'b1
  } arb_side_e;

  arb_side_e          prio_side;
  logic               pending_read;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [WORD_W-1:0]  fifo_mem [OUT_DEPTH];

  logic               active;
  logic [CNT_W:0]     credit_used;
  logic               rd_ok;
  logic               wr_cand;
  logic               rd_cand;
  logic               contended;
  logic               wr_gnt;
  logic               rd_gnt;
  logic               push;
  logic               pop;

  // Grant selection: a lone candidate wins; on contention the priority side wins.
  always_comb begin
    active      = clk_en & ~reset;
    credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(pending_read);
    rd_ok       = credit_used < (CNT_W + 1)'(OUT_DEPTH);
    wr_cand     = active & wr_valid;
    rd_cand     = active & rd_valid & rd_ok;
    contended   = wr_cand & rd_cand;
    wr_gnt      = wr_cand & (~rd_cand | (prio_side == SIDE_WRITE));
    rd_gnt      = rd_cand & (~wr_cand | (prio_side == SIDE_READ));
    push        = active & pending_read;
    pop         = active & rd_data_valid & rd_data_ready;
  end

  // Bank pins and handshake outputs follow the grant directly; idle pins are 0.
  always_comb begin
    wr_ready         = wr_gnt;
    rd_ready         = rd_gnt;
    mem_cen_in_bank  = wr_gnt | rd_gnt;
    mem_wen_in_bank  = wr_gnt;
    mem_addr_in_bank = '0;
    mem_data_in_bank = '0;
    if (wr_gnt) begin
      mem_addr_in_bank = wr_addr;
      mem_data_in_bank = wr_data;
    end else if (rd_gnt) begin
      mem_addr_in_bank = rd_addr;
    end
    rd_data_valid = ~reset & (fifo_count != '0);
    rd_data       = rd_data_valid ? fifo_mem[head_ptr] : '0;
  end

  // Control state: pending read flag, FIFO pointers/count, arbitration priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_side    <= SIDE_READ;
      pending_read <= 1'b0;
      fifo_count   <= '0;
      head_ptr     <= '0;
      tail_ptr     <= '0;
    end else if (clk_en) begin
      // A capture clears the flag; a new read grant in the same cycle re-arms it.
      pending_read <= rd_gnt;
      if (push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // Only contended grants hand priority to the other side.
      if (contended) begin
        prio_side <= (prio_side == SIDE_READ) ? SIDE_WRITE : SIDE_READ;
      end
    end
  end

  // Response storage: bank output captured the first enabled cycle after a read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_ptr] <= mem_data_out_bank;
    end
  end

endmodule
